shift_sequencer: RTL and testbench

Parametrised multi-mode register for the lab datapath: parallel load, clear, and multi-cycle shift/rotate by a requested amount, one bit position per clock. A start/ready/done handshake means a controller FSM can issue an operation and wait for completion. It replaces fixed-width plain registers wherever a datapath stage needs shift capability.

---
 rtl/shift_sequencer_pkg.sv | 21 ++
 rtl/shift_sequencer_step.sv | 27 ++
 rtl/shift_sequencer.sv | 103 ++++++++++
 tb/tb_shift_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared operation and state encodings for the shift sequencer.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    MODE_NOP   = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_CLEAR = 3'd2,
    MODE_SHL   = 3'd3,
    MODE_SHR   = 3'd4,
    MODE_ASR   = 3'd5,
    MODE_ROL   = 3'd6,
    MODE_ROR   = 3'd7
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_step.sv
// One single-bit shift/rotate step; non-shift modes pass q through.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t             mode,
  input  logic [WIDTH-1:0]  q,
  input  logic              sin,
  output logic [WIDTH-1:0]  next_q,
  output logic              out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin next_q = {q[WIDTH-2:0], sin};        out_bit = q[WIDTH-1]; end
      MODE_SHR: begin next_q = {sin, q[WIDTH-1:1]};        out_bit = q[0];       end
      MODE_ASR: begin next_q = {q[WIDTH-1], q[WIDTH-1:1]}; out_bit = q[0];       end
      MODE_ROL: begin next_q = {q[WIDTH-2:0], q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
      MODE_ROR: begin next_q = {q[0], q[WIDTH-1:1]};       out_bit = q[0];       end
      default:  ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-mode register: load/clear in one cycle, shift/rotate one bit per clock,
// with a start/ready/busy/done handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;

  mode_t            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  // The first step happens on the accept edge, so IDLE steps with the live mode.
  assign step_mode = (state_q == ST_IDLE) ? mode_t'(mode) : mode_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode    (step_mode),
    .q       (q_q),
    .sin     (sin),
    .next_q  (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          state_d = ST_DONE;
          case (mode_t'(mode))
            MODE_NOP:   ;
            MODE_LOAD:  q_d = d;
            MODE_CLEAR: q_d = '0;
            default: begin
              if (amount != '0) begin
                q_d    = step_q;
                sout_d = step_out;
                cnt_d  = amount - CNT_W'(1);
                if (amount != CNT_W'(1)) state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        q_d    = step_q;
        sout_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NOP;
      cnt_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
    end
  end

  assign q     = q_q;
  assign sout  = sout_q;
  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=8) with an expected-result queue.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] amount = 4'd0;
  logic [7:0] d = 8'd0;
  logic       sin = 1'b0;
  logic [7:0] q;
  logic       sout, ready, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       s;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .d(d), .sin(sin), .q(q), .sout(sout), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] dd,
                       input logic s, input bit push, input logic [7:0] eq, input logic es);
    exp_t e;
    @(negedge clk);
    start = 1'b1; mode = m; amount = amt; d = dd; sin = s;
    @(posedge clk); #1;
    start = 1'b0; mode = 3'd1; amount = 4'hF; d = 8'hAA;
    if (push) begin
      e.q = eq; e.s = es;
      sb.push_back(e);
    end
  endtask

  // Follow an operation to its done pulse, then compare against the queue head.
  task automatic wait_done(input string tag, input int exp_busy);
    int   busy_cnt = 0;
    int   ready_hi = 0;
    int   cyc = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && cyc < 200) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_cnt++;
        if (ready) ready_hi++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(q), 32'(e.q));
      chk({tag, "_sout"}, 32'(sout), 32'(e.s));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      chk({tag, "_ready_low"}, 32'(ready_hi), 32'd0);
      chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    end
  endtask

  initial begin
    int done_cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;

    issue(MODE_LOAD, 4'd0, 8'd65, 1'b0, 1, 8'h41, 1'b0);
    chk("load65_done_at_t0", 32'(done), 32'd1);
    wait_done("load65", 0);

    issue(MODE_LOAD, 4'd0, 8'h81, 1'b0, 1, 8'h81, 1'b0); wait_done("ld81", 0);
    issue(MODE_ROL, 4'd3, 8'h00, 1'b0, 1, 8'h0C, 1'b0);  wait_done("rol3", 2);

    issue(MODE_LOAD, 4'd0, 8'hF1, 1'b0, 1, 8'hF1, 1'b0); wait_done("ldF1", 0);
    issue(MODE_ASR, 4'd2, 8'h00, 1'b0, 1, 8'hFC, 1'b0);  wait_done("asr2", 1);

    issue(MODE_LOAD, 4'd0, 8'h49, 1'b1, 1, 8'h49, 1'b0); wait_done("ld49", 0);
    issue(MODE_SHL, 4'd2, 8'h00, 1'b1, 1, 8'h27, 1'b1);  wait_done("shl2", 1);

    issue(MODE_LOAD, 4'd0, 8'h5D, 1'b0, 1, 8'h5D, 1'b1); wait_done("ld5D", 0);
    issue(MODE_SHR, 4'd0, 8'h00, 1'b1, 1, 8'h5D, 1'b1);
    chk("shr0_done_at_t0", 32'(done), 32'd1);
    wait_done("shr0", 0);

    issue(MODE_LOAD, 4'd0, 8'hC6, 1'b0, 1, 8'hC6, 1'b1); wait_done("ldC6", 0);
    issue(MODE_ROR, 4'd8, 8'h00, 1'b0, 1, 8'hC6, 1'b1);  wait_done("ror8", 7);

    // A LOAD request while busy must be dropped.
    issue(MODE_LOAD, 4'd0, 8'hB4, 1'b0, 1, 8'hB4, 1'b1); wait_done("ldB4", 0);
    issue(MODE_ROL, 4'd5, 8'h00, 1'b0, 1, 8'h96, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = MODE_LOAD; d = 8'hFF;
    chk("rol5_ready_while_busy", 32'(ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("rol5", 3);
    repeat (2) @(posedge clk);
    #1;
    chk("rol5_q_after_idle", 32'(q), 32'h96);
    chk("rol5_idle_done", 32'(done), 32'd0);

    // Reset during the third step of a shift aborts without done.
    issue(MODE_LOAD, 4'd0, 8'hFF, 1'b0, 1, 8'hFF, 1'b0); wait_done("ldFF", 0);
    issue(MODE_SHL, 4'd6, 8'h00, 1'b0, 0, 8'h00, 1'b0);
    chk("abort_sout_pre", 32'(sout), 32'd1);
    @(posedge clk); #1;
    chk("abort_q_step2", 32'(q), 32'hFC);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    issue(MODE_LOAD, 4'd0, 8'h5A, 1'b0, 1, 8'h5A, 1'b0); wait_done("ld5A", 0);
    issue(MODE_CLEAR, 4'd0, 8'h77, 1'b0, 1, 8'h00, 1'b0); wait_done("clear", 0);

    // Shift past the width: ones from sin fill q and the last bits out are sin.
    issue(MODE_SHL, 4'd10, 8'h00, 1'b1, 1, 8'hFF, 1'b1); wait_done("shl10", 9);
    issue(MODE_NOP, 4'd3, 8'h12, 1'b0, 1, 8'hFF, 1'b1);  wait_done("nop", 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
